// File: rtl/pc_controller.sv
// Program counter and fetch sequencer: start/stall/redirect/flush/halt for one lane.
// ex_instruction carries the 4-bit ALU opcode; only BEQZ, BEQO and JAL affect control flow.
module pc_controller #(
    parameter int unsigned             ADDR_WIDTH   = 12,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC     = '0,
    parameter int unsigned             PC_STEP      = 1,
    parameter int unsigned             FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  stall,
    input  logic                  halt_req,
    input  logic                  ex_valid,
    input  logic [3:0]            ex_instruction,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [31:0]           ex_imm,
    input  logic [31:0]           ex_result,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fetch_valid,
    output logic                  squash,
    output logic                  redirect,
    output logic                  busy,
    output logic                  done
);

    // state  | meaning
    // IDLE   | out of reset, waiting for start
    // RUN    | fetching sequentially, evaluating control flow at execute
    // FLUSH  | redirected; squashing wrong-path instructions still in flight
    // HALTED | program finished, waiting for a restart
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} state_t;

    localparam logic [3:0]            OP_BEQZ = 4'hA;
    localparam logic [3:0]            OP_BEQO = 4'hB;
    localparam logic [3:0]            OP_JAL  = 4'hC;
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);
    localparam logic [2:0]            FLUSH_N = 3'(FLUSH_CYCLES);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    redirect_q, redirect_d;
    logic                    done_q, done_d;
    logic                    is_branch;
    logic                    taken;
    logic [ADDR_WIDTH-1:0]   target;
    logic                    active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        done_d     = 1'b0;
        is_branch  = (ex_instruction == OP_BEQZ) || (ex_instruction == OP_BEQO);
        active     = (state_q == RUN) || (state_q == FLUSH);
        taken      = (state_q == RUN) && ex_valid &&
                     ((is_branch && (ex_result == 32'd1)) || (ex_instruction == OP_JAL));
        target     = (ex_instruction == OP_JAL) ? ex_result[ADDR_WIDTH-1:0]
                                                : ex_pc + ex_imm[ADDR_WIDTH-1:0];

        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = start_pc;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (taken) begin
                    pc_d       = target;
                    cnt_d      = FLUSH_N;
                    state_d    = FLUSH;
                    redirect_d = ~halt_req;
                end else if (!stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            FLUSH: begin
                if (!stall) pc_d = pc_q + STEP;
                // Only consumed (live) wrong-path instructions count toward the flush.
                if (ex_valid) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Halt overrides the state change but keeps any pc update above.
        if (active && halt_req) begin
            state_d = HALTED;
            done_d  = 1'b1;
        end
    end

    assign pc          = pc_q;
    assign busy        = (state_q == RUN) || (state_q == FLUSH);
    assign fetch_valid = busy && !stall;
    assign squash      = (state_q == FLUSH) && ex_valid;
    assign redirect    = redirect_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pc_controller.sv
// Directed self-checking bench for pc_controller with hand-computed expectations.
module tb_pc_controller;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_BEQO = 4'hB;
    localparam logic [3:0] OP_JAL  = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] start_pc;
    logic        stall;
    logic        halt_req;
    logic        ex_valid;
    logic [3:0]  ex_instruction;
    logic [11:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_result;
    logic [11:0] pc;
    logic        fetch_valid, squash, redirect, busy, done;

    int checks = 0;
    int errors = 0;

    pc_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stall(stall),
        .halt_req(halt_req), .ex_valid(ex_valid), .ex_instruction(ex_instruction),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_result(ex_result), .pc(pc),
        .fetch_valid(fetch_valid), .squash(squash), .redirect(redirect),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_instruction = OP_ADD; ex_pc = '0; ex_imm = '0; ex_result = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; start_pc = '0; stall = 1'b0; halt_req = 1'b0;
        clear_ex();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic [11:0] addr);
        start = 1'b1; start_pc = addr;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_pc = '0; stall = 1'b0; halt_req = 1'b0;
        clear_ex();
        #3;
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", pc); end
        checks++; if ({fetch_valid, squash, redirect, busy, done} !== 5'b0) begin errors++;
            $display("FAIL reset_outs got=%b exp=00000", {fetch_valid, squash, redirect, busy, done}); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_start();
        do_reset();
        do_start(12'h010);
        checks++; if (pc !== 12'h010 || fetch_valid !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL start_0 pc=%h fv=%b busy=%b exp 010/1/1", pc, fetch_valid, busy); end
        tick();
        checks++; if (pc !== 12'h011) begin errors++; $display("FAIL start_1 got=%h exp=011", pc); end
        tick();
        checks++; if (pc !== 12'h012) begin errors++; $display("FAIL start_2 got=%h exp=012", pc); end
        start = 1'b1; start_pc = 12'h700;
        tick();
        start = 1'b0;
        checks++; if (pc !== 12'h013) begin errors++; $display("FAIL start_ignored got=%h exp=013", pc); end
    endtask

    task automatic test_branch();
        do_reset();
        do_start(12'h020);
        ex_valid = 1'b1; ex_instruction = OP_BEQZ; ex_pc = 12'h01E; ex_imm = 32'h40; ex_result = 32'd1;
        #1;
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL run_squash got=%b exp=0", squash); end
        tick();
        checks++; if (pc !== 12'h05E || redirect !== 1'b1) begin errors++;
            $display("FAIL beqz_taken pc=%h redirect=%b exp 05E/1", pc, redirect); end
        ex_instruction = OP_ADD; ex_result = 32'd7;
        #1;
        checks++; if (squash !== 1'b1) begin errors++; $display("FAIL flush_sq1 got=%b exp=1", squash); end
        tick();
        checks++; if (redirect !== 1'b0 || pc !== 12'h05F) begin errors++;
            $display("FAIL flush_step redirect=%b pc=%h exp 0/05F", redirect, pc); end
        checks++; if (squash !== 1'b1) begin errors++; $display("FAIL flush_sq2 got=%b exp=1", squash); end
        tick();
        checks++; if (squash !== 1'b0 || pc !== 12'h060 || busy !== 1'b1) begin errors++;
            $display("FAIL flush_end squash=%b pc=%h busy=%b exp 0/060/1", squash, pc, busy); end
        clear_ex();
        do_reset();
        do_start(12'h020);
        ex_valid = 1'b1; ex_instruction = OP_BEQZ; ex_pc = 12'h01E; ex_imm = 32'h40; ex_result = 32'd0;
        tick();
        clear_ex();
        checks++; if (pc !== 12'h021 || redirect !== 1'b0) begin errors++;
            $display("FAIL beqz_not_taken pc=%h redirect=%b exp 021/0", pc, redirect); end
    endtask

    task automatic test_jal_stall();
        do_reset();
        do_start(12'h030);
        stall = 1'b1; ex_valid = 1'b1; ex_instruction = OP_JAL; ex_result = 32'h0000_0123;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL jal_stall_fv got=%b exp=0", fetch_valid); end
        tick();
        checks++; if (pc !== 12'h123 || redirect !== 1'b1) begin errors++;
            $display("FAIL jal_stall pc=%h redirect=%b exp 123/1", pc, redirect); end
        stall = 1'b0; ex_result = 32'h0000_0200;
        #1;
        checks++; if (squash !== 1'b1) begin errors++; $display("FAIL jal_flush_sq got=%b exp=1", squash); end
        tick();
        clear_ex();
        checks++; if (pc !== 12'h124 || redirect !== 1'b0) begin errors++;
            $display("FAIL jal_in_flush pc=%h redirect=%b exp 124/0", pc, redirect); end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        do_start(12'hFFF);
        tick();
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap got=%h exp=000", pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv%0d got=%b exp=0", i, fetch_valid); end
            tick();
            checks++; if (pc !== 12'h000) begin errors++; $display("FAIL stall_pc%0d got=%h exp=000", i, pc); end
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL unstall got=%h exp=001", pc); end
    endtask

    task automatic test_halt();
        int ndone;
        do_reset();
        do_start(12'h040);
        ex_valid = 1'b1; ex_instruction = OP_BEQO; ex_pc = 12'h040; ex_imm = 32'h10; ex_result = 32'd1;
        halt_req = 1'b1;
        tick();
        clear_ex();
        halt_req = 1'b0;
        ndone = 0;
        checks++; if (pc !== 12'h050 || fetch_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL halt_state pc=%h fv=%b busy=%b exp 050/0/0", pc, fetch_valid, busy); end
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL done_pulses got=%0d exp=1", ndone); end
        checks++; if (pc !== 12'h050) begin errors++; $display("FAIL halt_hold got=%h exp=050", pc); end
        do_start(12'h080);
        checks++; if (pc !== 12'h080 || busy !== 1'b1 || fetch_valid !== 1'b1) begin errors++;
            $display("FAIL restart pc=%h busy=%b fv=%b exp 080/1/1", pc, busy, fetch_valid); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        do_start(12'h100);
        ex_valid = 1'b1; ex_instruction = OP_JAL; ex_result = 32'h300;
        tick();
        ex_instruction = OP_ADD;
        #1;
        checks++; if (squash !== 1'b1 || redirect !== 1'b1) begin errors++;
            $display("FAIL pre_rst squash=%b redirect=%b exp 1/1", squash, redirect); end
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 12'h000 || {fetch_valid, squash, redirect, busy, done} !== 5'b0) begin errors++;
            $display("FAIL async_rst pc=%h outs=%b exp 000/00000", pc, {fetch_valid, squash, redirect, busy, done}); end
        clear_ex();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start();
        test_branch();
        test_jal_stall();
        test_wrap_stall();
        test_halt();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
Name: pc_controller

Overview:
- Program-counter and fetch-sequencing stage upstream of the execute ALU.
- Holds the architectural PC and drives instruction fetch.
- Consumes the ALU result for control-flow instructions (BEQZ, BEQO, JAL) to redirect fetch, and squashes wrong-path instructions already in flight.
- Sequences start, stall, redirect/flush and halt for one compute lane.

Parameters:
- ADDR_WIDTH, 12, width of instruction_memory_address_t; PC arithmetic is modulo 2^ADDR_WIDTH.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, sequential increment (word-addressed instruction memory).
- FLUSH_CYCLES, 2, number of in-flight instructions between fetch and execute to squash after a redirect; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; loads start_pc and begins fetching (accepted only in IDLE or HALTED).
- start_pc  in  ADDR_WIDTH  initial fetch address.
- stall  in  1  downstream back-pressure; holds the PC.
- halt_req  in  1  stop fetching (end of program / kernel exit).
- ex_valid  in  1  execute stage holds a live instruction this cycle.
- ex_instruction  in  alu_instruction_t  opcode at execute.
- ex_pc  in  ADDR_WIDTH  PC of the instruction at execute.
- ex_imm  in  32  immediate of the instruction at execute.
- ex_result  in  32  ALU Result for that instruction.
- pc  out  ADDR_WIDTH  current fetch address.
- fetch_valid  out  1  pc is a valid fetch request this cycle.
- squash  out  1  instruction at execute is wrong-path; it must not write back.
- redirect  out  1  registered one-cycle pulse, high on the cycle after a taken branch or jump.
- busy  out  1  state is RUN or FLUSH.
- done  out  1  one-cycle pulse on entry to HALTED.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC, flush counter=0.
  - fetch_valid, squash, redirect, busy, done all 0.
  - Takes effect mid-operation with no drain.
- States: IDLE, RUN, FLUSH, HALTED.
- IDLE/HALTED:
  - fetch_valid=0; pc holds its value.
  - start=1 -> pc<=start_pc, state<=RUN on the next edge.
- Taken condition (evaluated combinationally in RUN only):
  - ex_valid=1, and one of:
    - ex_instruction=BEQZ or BEQO with ex_result==1;
    - ex_instruction=JAL, unconditionally.
- Target:
  - BEQZ/BEQO: ex_pc + ex_imm[ADDR_WIDTH-1:0], truncated to ADDR_WIDTH.
  - JAL: ex_result[ADDR_WIDTH-1:0] (the ALU already computes pc+IMM).
- RUN:
  - fetch_valid = ~stall.
  - Taken condition -> pc<=target, counter<=FLUSH_CYCLES, redirect<=1 next cycle, state<=FLUSH. Redirect has priority over stall.
  - Otherwise, stall=0 -> pc<=pc+PC_STEP, wrapping modulo 2^ADDR_WIDTH (max address -> 0).
  - Otherwise, stall=1 -> pc holds.
- FLUSH:
  - squash = ex_valid; branch evaluation is suppressed, so a wrong-path BEQZ/JAL cannot redirect.
  - fetch_valid = ~stall; pc advances from the target as in RUN.
  - Counter decrements once per cycle with ex_valid=1, i.e. only when a squashed instruction is consumed.
  - Counter reaching 0 -> state<=RUN.
- halt_req:
  - Sampled in RUN or FLUSH -> state<=HALTED next edge, done=1 for one cycle, fetch_valid=0 from that edge on.
  - halt_req and taken in the same cycle: halt wins; pc still loads the target so it is observable.
- start in RUN or FLUSH is ignored.
- squash is always 0 outside FLUSH.
- busy is a decode of state.
- Not-taken BEQZ/BEQO (ex_result==0): no effect.
- Any other opcode is ignored for control flow.

Test Plan:
- Reset then start=1, start_pc=0x010, no stall -> fetch_valid=1 and pc = 0x010, 0x011, 0x012 on consecutive cycles; busy=1.
- In RUN, pc=0x020: ex_valid=1, BEQZ, ex_pc=0x01E, ex_imm=0x40, ex_result=1 -> next cycle pc=0x05E, redirect=1. Then squash=1 on the next 2 ex_valid cycles, then state returns to RUN. The same stimulus with ex_result=0 -> no redirect, pc continues 0x021.
- JAL with ex_result=0x0000_0123 while stall=1 -> pc=0x123 next cycle despite stall; a JAL arriving during FLUSH is squashed with no second redirect.
- pc=0xFFF, stall=0 -> next pc=0x000, no error; stall=1 for 3 cycles -> pc constant and fetch_valid=0 during those cycles.
- halt_req in the same cycle as a taken BEQO -> state HALTED, done pulses exactly once, fetch_valid=0; start then restarts from the new start_pc.
- rst_n asserted mid-FLUSH -> all outputs 0 and pc=RESET_PC immediately, without waiting for a clock edge.
